inst_fetch: RTL

- Instruction fetch stage. Sits directly upstream of the RV32I instruction decoder.
- Owns the program counter and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to the decoder through a valid/ready interface.
- Accepts redirects (branch/jump/trap targets) from the execute stage and flushes all wrong-path state.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/inst_fetch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } fetch_state_t;

    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries; flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [AW:0]  count,
    output logic         empty,
    output logic         full
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot the simultaneous push needs when full.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!n_reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (n_reset && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, one outstanding imem request at a time,
// buffers {pc, inst} for the decoder and flushes wrong-path state on redirect.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        n_reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   pc;
    logic [31:0]   pc_nxt;
    logic [31:0]   req_pc;
    logic          post_reset;
    fetch_entry_t  push_data;
    fetch_entry_t  head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop_fire;
    logic          outstanding;
    logic          space_now;
    logic          space_after_push;

    assign outstanding      = (state == WAIT) || (state == DISCARD);
    assign pop_fire         = inst_valid && inst_ready;
    assign space_now        = (fifo_count + CW'(outstanding)) < CW'(FIFO_DEPTH);
    assign space_after_push = (fifo_count + CW'(1) - CW'(pop_fire)) < CW'(FIFO_DEPTH);
    assign push_data        = '{pc: req_pc, inst: imem_rdata};

    assign imem_addr   = pc;
    assign inst_valid  = !fifo_empty;
    assign instruction = head.inst;
    assign inst_pc     = head.pc;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        imem_req  = 1'b0;
        push      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!redirect_valid && space_now) state_nxt = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    // A grant in the redirect cycle still owes us a response.
                    state_nxt = imem_gnt ? DISCARD : IDLE;
                end else if (imem_gnt) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        state_nxt = IDLE;
                    end else begin
                        push      = 1'b1;
                        state_nxt = space_after_push ? REQ : IDLE;
                    end
                end else if (redirect_valid) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (redirect_valid) pc_nxt = word_align(redirect_pc);
    end

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_pc     <= '0;
            post_reset <= 1'b1;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == REQ && imem_gnt) begin
                req_pc     <= pc;
                post_reset <= 1'b0;
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .n_reset   (n_reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop_fire),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // A late response to a request cut off by reset may land before the
    // first new grant; only after that is a stray rvalid a protocol error.
    always_ff @(posedge clock) begin
        if (n_reset) begin
            assert (!(push && fifo_full && !pop_fire));
            assert (post_reset || !(imem_rvalid && (state == IDLE || state == REQ)));
        end
    end

endmodule
